keypad_scan_controller: RTL and testbench

KEYPAD_SCAN_CONTROLLER -- requirements
Module: keypad_scan_controller

---
 rtl/keypad_scan_controller.sv | 192 +++++++++++++++++++
 tb/tb_keypad_scan_controller.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan_controller.sv
// 4x3 matrix keypad scanner with per-row-slot sampling, press/release debounce
// and a valid/ack handshake that drops keys accepted while one is still pending.
module keypad_scan_controller #(
    parameter int SCAN_DIV = 4,
    parameter int DEBOUNCE = 3
) (
    input  logic       clk,
    input  logic       initialize,
    input  logic       col1,
    input  logic       col2,
    input  logic       col3,
    output logic       row1,
    output logic       row2,
    output logic       row3,
    output logic       row4,
    input  logic       key_ack,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic       key_held,
    output logic       overrun
);

    typedef enum logic [1:0] {
        SCAN       = 2'd0,
        PRESS_DB   = 2'd1,
        HELD       = 2'd2,
        RELEASE_DB = 2'd3
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [7:0] div_cnt;
    logic [1:0] row_idx;
    logic [1:0] row_idx_next;
    logic [3:0] db_cnt;
    logic [3:0] db_cnt_next;
    logic [2:0] cap_cols;
    logic [2:0] cap_cols_next;
    logic [2:0] cols;
    logic       sample;
    logic       one_hot;
    logic       accept;
    logic [3:0] col_num;
    logic [3:0] code_now;

    assign cols    = {col3, col2, col1};
    assign sample  = (div_cnt == 8'(SCAN_DIV - 1));
    assign one_hot = (cols == 3'b001) || (cols == 3'b010) || (cols == 3'b100);

    assign row1 = (row_idx == 2'd0);
    assign row2 = (row_idx == 2'd1);
    assign row3 = (row_idx == 2'd2);
    assign row4 = (row_idx == 2'd3);

    assign key_held = (state == HELD) || (state == RELEASE_DB);

    // At acceptance the live columns equal the captured pattern, so decode them directly.
    always_comb begin
        col_num = 4'd1;
        if (cols[1]) begin
            col_num = 4'd2;
        end else if (cols[2]) begin
            col_num = 4'd3;
        end
        if (row_idx == 2'd3) begin
            if (col_num == 4'd1) begin
                code_now = 4'd10;
            end else if (col_num == 4'd2) begin
                code_now = 4'd0;
            end else begin
                code_now = 4'd11;
            end
        end else begin
            code_now = ({2'b00, row_idx} * 4'd3) + col_num;
        end
    end

    always_ff @(posedge clk or posedge initialize) begin
        if (initialize) begin
            div_cnt <= '0;
        end else if (sample) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge initialize) begin
        if (initialize) begin
            state    <= SCAN;
            row_idx  <= '0;
            db_cnt   <= '0;
            cap_cols <= '0;
        end else begin
            state    <= state_next;
            row_idx  <= row_idx_next;
            db_cnt   <= db_cnt_next;
            cap_cols <= cap_cols_next;
        end
    end

    always_comb begin
        state_next    = state;
        row_idx_next  = row_idx;
        db_cnt_next   = db_cnt;
        cap_cols_next = cap_cols;
        accept        = 1'b0;
        if (sample) begin
            case (state)
                SCAN: begin
                    if (one_hot) begin
                        cap_cols_next = cols;
                        if (DEBOUNCE == 1) begin
                            accept      = 1'b1;
                            state_next  = HELD;
                            db_cnt_next = '0;
                        end else begin
                            state_next  = PRESS_DB;
                            db_cnt_next = 4'd1;
                        end
                    end else begin
                        row_idx_next = row_idx + 2'd1;
                    end
                end
                PRESS_DB: begin
                    if (cols == cap_cols) begin
                        if (db_cnt == 4'(DEBOUNCE - 1)) begin
                            accept      = 1'b1;
                            state_next  = HELD;
                            db_cnt_next = '0;
                        end else begin
                            db_cnt_next = db_cnt + 4'd1;
                        end
                    end else begin
                        state_next   = SCAN;
                        db_cnt_next  = '0;
                        row_idx_next = row_idx + 2'd1;
                    end
                end
                HELD: begin
                    if (cols == 3'b000) begin
                        if (DEBOUNCE == 1) begin
                            state_next   = SCAN;
                            row_idx_next = row_idx + 2'd1;
                        end else begin
                            state_next  = RELEASE_DB;
                            db_cnt_next = 4'd1;
                        end
                    end
                end
                RELEASE_DB: begin
                    if (cols != 3'b000) begin
                        state_next  = HELD;
                        db_cnt_next = '0;
                    end else if (db_cnt == 4'(DEBOUNCE - 1)) begin
                        state_next   = SCAN;
                        db_cnt_next  = '0;
                        row_idx_next = row_idx + 2'd1;
                    end else begin
                        db_cnt_next = db_cnt + 4'd1;
                    end
                end
                default: begin
                    state_next  = SCAN;
                    db_cnt_next = '0;
                end
            endcase
        end
    end

    // An ack on the accepting edge frees the slot, so the new key replaces the old one.
    always_ff @(posedge clk or posedge initialize) begin
        if (initialize) begin
            key_valid <= 1'b0;
            key_code  <= '0;
            overrun   <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (accept) begin
                if (!key_valid || key_ack) begin
                    key_valid <= 1'b1;
                    key_code  <= code_now;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (key_valid && key_ack) begin
                key_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_keypad_scan_controller.sv
// Bench for keypad_scan_controller: a physical keypad model drives the columns,
// expected key codes are queued when a press is staged and matched on presentation.
`timescale 1ns/1ps
module tb_keypad_scan_controller;

    logic       clk;
    logic       initialize;
    logic       col1, col2, col3;
    logic       row1, row2, row3, row4;
    logic       key_ack;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_held;
    logic       overrun;

    int unsigned n_total = 0;
    int unsigned n_bad   = 0;
    int          ovr_cnt = 0;
    int          base;
    logic [3:0]  exp_q[$];

    logic       kp_on;
    logic [1:0] kp_row;
    logic [2:0] kp_cols;
    logic [3:0] rows_v;
    logic       valid_s;
    logic       ack_s;

    keypad_scan_controller #(.SCAN_DIV(4), .DEBOUNCE(3)) dut (
        .clk        (clk),
        .initialize (initialize),
        .col1       (col1),
        .col2       (col2),
        .col3       (col3),
        .row1       (row1),
        .row2       (row2),
        .row3       (row3),
        .row4       (row4),
        .key_ack    (key_ack),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .key_held   (key_held),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The pressed key only closes its column while its own row is driven.
    assign rows_v = {row4, row3, row2, row1};
    assign {col3, col2, col1} = (kp_on && rows_v[kp_row]) ? kp_cols : 3'b000;

    always @(posedge clk) begin
        valid_s <= key_valid;
        ack_s   <= key_ack;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(input logic [1:0] r, input logic [2:0] c);
        kp_row  = r;
        kp_cols = c;
        kp_on   = 1'b1;
    endtask

    task automatic release_key();
        kp_on = 1'b0;
    endtask

    task automatic wait_row(input int idx);
        int k;
        k = 0;
        while (rows_v[idx] && k < 100) begin
            tick(1);
            k++;
        end
        while (!rows_v[idx] && k < 100) begin
            tick(1);
            k++;
        end
        check("wait_row_in_time", k < 100, 1);
    endtask

    task automatic wait_valid(input logic want);
        int k;
        k = 0;
        while (key_valid !== want && k < 200) begin
            tick(1);
            k++;
        end
        check("wait_valid_in_time", k < 200, 1);
    endtask

    task automatic wait_held(input logic want);
        int k;
        k = 0;
        while (key_held !== want && k < 200) begin
            tick(1);
            k++;
        end
        check("wait_held_in_time", k < 200, 1);
    endtask

    // Scoreboard: a new presentation is a rising key_valid or a reload on an acked edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (overrun === 1'b1) ovr_cnt++;
            if (!initialize && key_valid && (!valid_s || ack_s)) begin
                check("presentation_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) check("presented_code", key_code, exp_q.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        initialize = 1'b1;
        key_ack    = 1'b0;
        kp_on      = 1'b0;
        kp_row     = 2'd0;
        kp_cols    = 3'b000;
        tick(2);
        check("rst_rows", rows_v, 4'b0001);
        check("rst_valid", key_valid, 0);
        check("rst_code", key_code, 0);
        check("rst_held", key_held, 0);
        check("rst_overrun", overrun, 0);

        // Key "5" held steady: valid appears 9 cycles after the first row2 sample.
        press(2'd1, 3'b010);
        exp_q.push_back(4'd5);
        initialize = 1'b0;
        wait_row(1);
        tick(11);
        check("k5_not_yet_valid", key_valid, 0);
        check("k5_row_frozen", rows_v, 4'b0010);
        tick(1);
        check("k5_valid", key_valid, 1);
        check("k5_code", key_code, 5);
        check("k5_held", key_held, 1);
        check("k5_row2", rows_v, 4'b0010);
        key_ack = 1'b1;
        tick(1);
        key_ack = 1'b0;
        check("k5_acked", key_valid, 0);
        release_key();
        wait_held(1'b0);

        // Single-sample glitch on row2: dropped, rotation resumes at row3.
        wait_row(1);
        press(2'd1, 3'b010);
        tick(4);
        release_key();
        check("glitch_row_frozen", rows_v, 4'b0010);
        tick(4);
        check("glitch_resume_row3", rows_v, 4'b0100);
        tick(30);
        check("glitch_no_valid", key_valid, 0);
        check("glitch_no_held", key_held, 0);

        // Key "1" pending, then "0" accepted on the same edge as its ack.
        press(2'd0, 3'b001);
        exp_q.push_back(4'd1);
        wait_valid(1'b1);
        check("k1_code", key_code, 1);
        release_key();
        wait_held(1'b0);
        wait_row(3);
        press(2'd3, 3'b010);
        exp_q.push_back(4'd0);
        base = ovr_cnt;
        tick(11);
        check("k0_old_code_kept", key_code, 1);
        key_ack = 1'b1;
        tick(1);
        key_ack = 1'b0;
        check("k0_valid_stays", key_valid, 1);
        check("k0_code", key_code, 0);
        tick(2);
        check("k0_no_overrun", ovr_cnt - base, 0);
        key_ack = 1'b1;
        tick(1);
        key_ack = 1'b0;
        check("k0_acked", key_valid, 0);
        key_ack = 1'b1;
        tick(3);
        key_ack = 1'b0;
        check("ack_idle_ignored", key_valid, 0);
        check("k0_still_held", key_held, 1);
        release_key();
        wait_held(1'b0);

        // Two columns on row4: never accepted.
        press(2'd3, 3'b101);
        tick(60);
        check("multi_no_valid", key_valid, 0);
        check("multi_no_held", key_held, 0);
        release_key();
        tick(8);

        // Star, release, sharp without ack: star kept, one overrun pulse.
        press(2'd3, 3'b001);
        exp_q.push_back(4'd10);
        wait_valid(1'b1);
        check("star_code", key_code, 10);
        release_key();
        wait_held(1'b0);
        base = ovr_cnt;
        press(2'd3, 3'b100);
        wait_held(1'b1);
        tick(2);
        check("sharp_overrun_once", ovr_cnt - base, 1);
        check("sharp_code_kept", key_code, 10);
        check("sharp_valid_kept", key_valid, 1);
        release_key();
        wait_held(1'b0);
        check("sharp_overrun_single", ovr_cnt - base, 1);
        key_ack = 1'b1;
        tick(1);
        key_ack = 1'b0;
        check("star_acked", key_valid, 0);

        // Reset during debounce of "7": nothing presented, scan restarts at row1.
        wait_row(2);
        press(2'd2, 3'b001);
        tick(5);
        check("k7_debouncing", key_held, 0);
        initialize = 1'b1;
        tick(1);
        check("mid_rst_rows", rows_v, 4'b0001);
        check("mid_rst_valid", key_valid, 0);
        check("mid_rst_code", key_code, 0);
        check("mid_rst_held", key_held, 0);
        check("mid_rst_overrun", overrun, 0);
        release_key();
        tick(2);
        initialize = 1'b0;
        tick(1);
        check("restart_row1", rows_v, 4'b0001);
        tick(3);
        check("restart_row2", rows_v, 4'b0010);
        tick(40);
        check("after_rst_no_valid", key_valid, 0);
        check("queue_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
